// File: rtl/instr_fetch_unit.sv
// Fetch-side initiator for a 1-cycle-latency synchronous program ROM.
// Pairs each returned word with its address and presents it to the decoder behind a one-entry hold buffer.
module instr_fetch_unit #(
    parameter int               PC_W     = 10,
    parameter int               INSTR_W  = 16,
    parameter logic [PC_W-1:0]  RESET_PC = '0
) (
    input  logic               clk,
    input  logic               reset,
    output logic [PC_W-1:0]    oPC,
    input  logic [INSTR_W-1:0] iInstr,
    input  logic               iStall,
    input  logic               iBranchTaken,
    input  logic [PC_W-1:0]    iBranchTarget,
    output logic [INSTR_W-1:0] oInstr,
    output logic [PC_W-1:0]    oInstrPC,
    output logic               oInstrValid
);

    localparam logic [1:0] S_BOOT = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_HOLD = 2'd2;

    logic [1:0]         state_q,      state_d;
    logic [PC_W-1:0]    pc_q,         pc_d;
    logic [PC_W-1:0]    fetch_pc_q,   fetch_pc_d;
    logic [INSTR_W-1:0] hold_instr_q, hold_instr_d;
    logic [PC_W-1:0]    hold_pc_q,    hold_pc_d;
    logic [INSTR_W-1:0] out_instr_q,  out_instr_d;
    logic [PC_W-1:0]    out_pc_q,     out_pc_d;
    logic               out_valid_q,  out_valid_d;
    logic [PC_W-1:0]    pc_inc;

    // Wraps modulo 2^PC_W by construction.
    assign pc_inc = pc_q + PC_W'(1);

    always_comb begin
        // NOTE: every next-state value defaults to its register so no path infers a latch.
        state_d      = state_q;
        pc_d         = pc_q;
        fetch_pc_d   = fetch_pc_q;
        hold_instr_d = hold_instr_q;
        hold_pc_d    = hold_pc_q;
        out_instr_d  = out_instr_q;
        out_pc_d     = out_pc_q;
        out_valid_d  = out_valid_q;

        if (iBranchTaken) begin
            // Redirect drops both the in-flight ROM word and any held word.
            pc_d         = iBranchTarget;
            out_valid_d  = 1'b0;
            hold_instr_d = '0;
            hold_pc_d    = '0;
            state_d      = S_BOOT;
        end else begin
            case (state_q)
                S_BOOT: begin
                    if (!iStall) begin
                        fetch_pc_d = pc_q;
                        pc_d       = pc_inc;
                        state_d    = S_RUN;
                    end
                end
                S_RUN: begin
                    if (iStall) begin
                        hold_instr_d = iInstr;
                        hold_pc_d    = fetch_pc_q;
                        state_d      = S_HOLD;
                    end else begin
                        out_instr_d = iInstr;
                        out_pc_d    = fetch_pc_q;
                        out_valid_d = 1'b1;
                        fetch_pc_d  = pc_q;
                        pc_d        = pc_inc;
                    end
                end
                S_HOLD: begin
                    // pc_q stayed frozen, so the ROM is returning ROM[pc_q] again on exit.
                    if (!iStall) begin
                        out_instr_d = hold_instr_q;
                        out_pc_d    = hold_pc_q;
                        out_valid_d = 1'b1;
                        fetch_pc_d  = pc_q;
                        pc_d        = pc_inc;
                        state_d     = S_RUN;
                    end
                end
                default: state_d = S_BOOT;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: reset is synchronous, so it lives inside the clocked branch rather than the sensitivity list.
        if (reset) begin
            state_q      <= S_BOOT;
            pc_q         <= RESET_PC;
            fetch_pc_q   <= RESET_PC;
            hold_instr_q <= '0;
            hold_pc_q    <= '0;
            out_instr_q  <= '0;
            out_pc_q     <= '0;
            out_valid_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            fetch_pc_q   <= fetch_pc_d;
            hold_instr_q <= hold_instr_d;
            hold_pc_q    <= hold_pc_d;
            out_instr_q  <= out_instr_d;
            out_pc_q     <= out_pc_d;
            out_valid_q  <= out_valid_d;
        end
    end

    assign oPC         = pc_q;
    assign oInstr      = out_instr_q;
    assign oInstrPC    = out_pc_q;
    assign oInstrValid = out_valid_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: registered ROM model, directed scenarios, then random stall/branch/reset traffic.
// A scoreboard of expected fetch addresses is checked by an independent negedge monitor.
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        stall = 1'b0;
    logic        br = 1'b0;
    logic [9:0]  tgt = '0;
    logic [9:0]  o_pc;
    logic [15:0] rom_q = '0;
    logic [15:0] o_instr;
    logic [9:0]  o_ipc;
    logic        o_valid;

    int checks = 0;
    int errors = 0;
    int accepted = 0;
    int idle = 0;

    // Expected stream of accepted addresses, in program order.
    logic [9:0] exp_q[$];
    logic [9:0] nxt = '0;
    logic       mon_en = 1'b0;
    logic       hold_chk = 1'b0;
    logic [9:0] hold_pc;
    logic [15:0] hold_instr;
    logic [9:0] e;

    always #5 clk = ~clk;

    // Synchronous ROM: ROM[a] = 16'hA000 | a, one cycle latency.
    always @(posedge clk) rom_q <= 16'hA000 | {6'd0, o_pc};

    instr_fetch_unit dut (
        .clk          (clk),
        .reset        (reset),
        .oPC          (o_pc),
        .iInstr       (rom_q),
        .iStall       (stall),
        .iBranchTaken (br),
        .iBranchTarget(tgt),
        .oInstr       (o_instr),
        .oInstrPC     (o_ipc),
        .oInstrValid  (o_valid)
    );

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", name, got, exp, $time);
        end
    endtask

    // Drive one cycle of inputs, let the edge happen, then update the reference stream.
    task automatic step(input logic r, input logic s, input logic b, input logic [9:0] t);
        reset = r;
        stall = s;
        br    = b;
        tgt   = t;
        @(posedge clk);
        if (r) begin
            exp_q.delete();
            nxt    = 10'h000;
            mon_en = 1'b1;
        end else if (b) begin
            exp_q.delete();
            nxt = t;
        end
        while (exp_q.size() < 4) begin
            exp_q.push_back(nxt);
            nxt = nxt + 10'd1;
        end
        #1;
    endtask

    task automatic expect_out(input string name, input logic v, input logic [9:0] pc);
        check({name, "_valid"}, 32'(o_valid), 32'(v));
        if (v) begin
            check({name, "_pc"},    32'(o_ipc),   32'(pc));
            check({name, "_instr"}, 32'(o_instr), 32'(16'hA000 | {6'd0, pc}));
        end
    endtask

    // Monitor: an instruction is consumed whenever it is valid and the decoder is not stalling.
    always @(negedge clk) begin
        if (mon_en) begin
            if (hold_chk) begin
                check("hold_valid", 32'(o_valid), 32'd1);
                check("hold_pc",    32'(o_ipc),   32'(hold_pc));
                check("hold_instr", 32'(o_instr), 32'(hold_instr));
            end
            hold_chk   = o_valid && stall && !br && !reset;
            hold_pc    = o_ipc;
            hold_instr = o_instr;

            if (o_valid && !stall) begin
                if (exp_q.size() == 0) begin
                    check("sb_empty", 32'd0, 32'd1);
                end else begin
                    e = exp_q.pop_front();
                    check("sb_pc",    32'(o_ipc),   32'(e));
                    check("sb_instr", 32'(o_instr), 32'(16'hA000 | {6'd0, e}));
                    accepted++;
                end
            end

            // At most two unstalled bubbles may separate a restart from its first valid word.
            if (o_valid) begin
                idle = 0;
            end else if (!stall) begin
                idle++;
                check("bubble_limit", 32'(idle <= 2), 32'd1);
            end
            if (reset || br) idle = 0;
        end
    end

    initial begin
        // Scenario 1: reset, then free run.
        step(1, 0, 0, 0);
        step(1, 0, 0, 0);
        check("rst_oPC", 32'(o_pc), 32'h000);
        expect_out("rst", 1'b0, 10'h000);
        check("rst_oInstr", 32'(o_instr), 32'h0);
        for (int i = 0; i < 7; i++) begin
            step(0, 0, 0, 0);
            if (i == 0) expect_out("boot", 1'b0, 10'h000);
            else        expect_out("run", 1'b1, 10'(i - 1));
        end

        // Scenario 2: stall three cycles while PC 5 is presented.
        for (int i = 0; i < 3; i++) begin
            step(0, 1, 0, 0);
            expect_out("stall5", 1'b1, 10'h005);
        end
        step(0, 0, 0, 0);
        expect_out("after_stall6", 1'b1, 10'h006);
        step(0, 0, 0, 0);
        expect_out("after_stall7", 1'b1, 10'h007);

        // Scenario 3: branch to 0x003.
        step(0, 0, 1, 10'h003);
        check("br3_oPC", 32'(o_pc), 32'h003);
        expect_out("br3_b1", 1'b0, 10'h000);
        step(0, 0, 0, 0);
        expect_out("br3_b2", 1'b0, 10'h000);
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 0, 0);
            expect_out("br3_seq", 1'b1, 10'(3 + i));
        end

        // Scenario 4: branch near the top of the address space and wrap.
        step(0, 0, 1, 10'h3FE);
        check("wrap_oPC0", 32'(o_pc), 32'h3FE);
        step(0, 0, 0, 0);
        check("wrap_oPC1", 32'(o_pc), 32'h3FF);
        step(0, 0, 0, 0);
        check("wrap_oPC2", 32'(o_pc), 32'h000);
        expect_out("wrap_a", 1'b1, 10'h3FE);
        step(0, 0, 0, 0);
        expect_out("wrap_b", 1'b1, 10'h3FF);
        step(0, 0, 0, 0);
        expect_out("wrap_c", 1'b1, 10'h000);
        step(0, 0, 0, 0);
        expect_out("wrap_d", 1'b1, 10'h001);

        // Scenario 5: branch and stall together; branch wins.
        step(0, 1, 1, 10'h010);
        check("brstall_oPC", 32'(o_pc), 32'h010);
        expect_out("brstall_b1", 1'b0, 10'h000);
        step(0, 0, 0, 0);
        expect_out("brstall_b2", 1'b0, 10'h000);
        step(0, 0, 0, 0);
        expect_out("brstall_first", 1'b1, 10'h010);

        // Scenario 6: reset in the middle of a stall at PC 9.
        step(0, 0, 1, 10'h007);
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        expect_out("pre9", 1'b1, 10'h009);
        step(0, 1, 0, 0);
        step(1, 1, 0, 0);
        check("rststall_oPC", 32'(o_pc), 32'h000);
        expect_out("rststall", 1'b0, 10'h000);
        step(0, 0, 0, 0);
        expect_out("rststall_boot", 1'b0, 10'h000);
        step(0, 0, 0, 0);
        expect_out("rststall_first", 1'b1, 10'h000);

        // Random traffic; the monitor and scoreboard do the checking.
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 299) == 0),
                 ($urandom_range(0, 2) == 0),
                 ($urandom_range(0, 15) == 0),
                 10'($urandom));
        end
        for (int i = 0; i < 6; i++) step(0, 0, 0, 0);
        check("random_progress", 32'(accepted > 1000), 32'd1);

        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
